// File: rtl/serial_barrel_shifter.sv
// Multi-cycle barrel shifter: captures one request, shifts the word one bit per
// clock, and pulses done when the result in out is final.
module serial_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SL_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SL_W-1:0]  sl,
  input  logic             left_of_right,
  input  logic [1:0]       logick_rotate_ariphmetic_shift,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SL_W-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] step;

  // Single-bit step; mode 11 falls into the arithmetic default.
  always_comb begin
    step = data_q;
    if (!dir_q) begin
      if (mode_q == 2'b01) step = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      else                 step = {data_q[WIDTH-2:0], 1'b0};
    end else begin
      case (mode_q)
        2'b00:   step = {1'b0,          data_q[WIDTH-1:1]};
        2'b01:   step = {data_q[0],     data_q[WIDTH-1:1]};
        default: step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = in;
          cnt_d   = sl;
          dir_d   = left_of_right;
          mode_d  = logick_rotate_ariphmetic_shift;
          state_d = (sl == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step;
        cnt_d  = cnt_q - SL_W'(1);
        if (cnt_q == SL_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign out  = data_q;

endmodule

// File: tb/tb_serial_barrel_shifter.sv
// Bench for serial_barrel_shifter: a cycle-timeline reference model checked every
// cycle, plus directed requests with hand-computed results.
module tb_serial_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_r = '0;
  logic [4:0]  sl_r = '0;
  logic        dir = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        busy, done;
  logic [31:0] out;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  serial_barrel_shifter #(.WIDTH(32), .SL_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in_r), .sl(sl_r),
    .left_of_right(dir), .logick_rotate_ariphmetic_shift(mode),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Full n-position shift computed directly with shift operators.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int n,
                                            input logic d, input logic [1:0] m);
    if (!d) begin
      if (m == 2'b01) return (v << n) | (v >> (32 - n));
      return v << n;
    end
    case (m)
      2'b00:   return v >> n;
      2'b01:   return (v >> n) | (v << (32 - n));
      default: return $unsigned($signed(v) >>> n);
    endcase
  endfunction

  // Timeline model: an accept in cycle acc occupies cycles acc+1 .. acc+sl+1.
  int          cyc = 0;
  bit          has_op = 1'b0;
  int          acc = 0, done_at = -1;
  logic [31:0] cap_in;
  int          cap_sl;
  logic        cap_dir;
  logic [1:0]  cap_mode;

  always @(posedge clk) begin
    if (rst) begin
      has_op  = 1'b0;
      done_at = -1;
    end else if ((!has_op || cyc > done_at) && start) begin
      has_op   = 1'b1;
      acc      = cyc;
      cap_in   = in_r;
      cap_sl   = int'(sl_r);
      cap_dir  = dir;
      cap_mode = mode;
      done_at  = cyc + cap_sl + 1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit          in_win;
      logic [31:0] exp_out;
      in_win = has_op && cyc > acc && cyc <= done_at;
      if (!has_op)     exp_out = '0;
      else if (in_win) exp_out = ref_shift(cap_in, cyc - acc - 1, cap_dir, cap_mode);
      else             exp_out = ref_shift(cap_in, cap_sl, cap_dir, cap_mode);
      check("model_busy", {31'b0, busy}, {31'b0, in_win});
      check("model_done", {31'b0, done}, {31'b0, has_op && cyc == done_at});
      check("model_out", out, exp_out);
    end
  end

  // Called on a falling edge; leaves on the falling edge of the cycle after done.
  task automatic run(input string nm, input logic [31:0] v, input logic [4:0] s,
                     input logic d, input logic [1:0] m, input logic [31:0] exp);
    int n;
    in_r = v; sl_r = s; dir = d; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(s) + 32'd1);
    check({nm, "_out"}, out, exp);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n, extra;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_out", out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("logic_left",  32'hFFFF0000, 5'd4,  1'b0, 2'b00, 32'hFFF00000);
    run("logic_right", 32'hFFFF0000, 5'd8,  1'b1, 2'b00, 32'h00FFFF00);
    run("rot_right",   32'h7FFF000A, 5'd4,  1'b1, 2'b01, 32'hA7FFF000);
    run("arith_right", 32'hFFFF0000, 5'd7,  1'b1, 2'b10, 32'hFFFFFE00);
    run("arith_left",  32'h7FFF0000, 5'd3,  1'b0, 2'b11, 32'hFFF80000);
    run("sl_zero",     32'h12345678, 5'd0,  1'b0, 2'b00, 32'h12345678);
    run("rot_left_31", 32'h00000001, 5'd31, 1'b0, 2'b01, 32'h80000000);
    run("arith_r_11",  32'h80000001, 5'd31, 1'b1, 2'b11, 32'hFFFFFFFF);
    run("rot_right_1", 32'h00000001, 5'd1,  1'b1, 2'b01, 32'h80000000);

    // A second start while busy must be ignored.
    in_r = 32'h000000F1; sl_r = 5'd6; dir = 1'b0; mode = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    in_r = 32'hFFFFFFFF; sl_r = 5'd1; dir = 1'b1; mode = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 3;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("ignore_latency", 32'(n), 32'd7);
    check("ignore_out", out, 32'h00003C40);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignore_no_extra_done", 32'(extra), 32'd0);

    // Reset in cycle 3 of an sl=10 request.
    in_r = 32'h00000001; sl_r = 5'd10; dir = 1'b0; mode = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_out", out, 32'd0);
    run("after_rst", 32'h00000003, 5'd2, 1'b0, 2'b00, 32'h0000000C);

    // start held high: back-to-back accepts, checked by the per-cycle model.
    in_r = 32'h0000000F; sl_r = 5'd2; dir = 1'b1; mode = 2'b01; start = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_barrel_shifter.md
# serial_barrel_shifter

Multi-cycle, area-lean companion to the combinational barrel shifter in the MIPS-based soft processor. It accepts one shift request through a start/busy/done handshake and shifts a captured word one bit position per clock. It uses the same direction and mode encoding as the combinational unit, so the two are interchangeable behind the ALU's shift decode. It is intended for low-area builds and as a cycle-accurate reference responder when the combinational shifter is exercised in simulation.

## Interface
- WIDTH, 32, data word width in bits
- SL_W, 5, shift-length width; must satisfy 2^SL_W == WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- start  input  1  request strobe; sampled only in IDLE
- in  input  WIDTH  operand
- sl  input  SL_W  shift length, 0..WIDTH-1
- left_of_right  input  1  0 = left, 1 = right
- logick_rotate_ariphmetic_shift  input  2  00 logic, 01 rotate, 10/11 arithmetic
- busy  output  1  high while a request is in progress (SHIFT and DONE)
- done  output  1  one-cycle pulse; out is valid in this cycle
- out  output  WIDTH  result register; holds its value until the next accepted request

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - when start=1 at the edge, capture in into the data register, sl into the counter, and direction/mode into registers. The input ports are not looked at again.
  - next state is DONE if sl==0, else SHIFT.
- SHIFT: each edge applies a 1-bit shift to the data register and decrements the counter. When the counter equals 1 at the edge, next state is DONE.
- DONE: done=1, busy=1; next state is IDLE unconditionally. start is ignored in this state.
- Per-bit step, left:
  - logic and arithmetic: {d[WIDTH-2:0], 0}
  - rotate: {d[WIDTH-2:0], d[WIDTH-1]}
- Per-bit step, right:
  - logic: {0, d[WIDTH-1:1]}
  - rotate: {d[0], d[WIDTH-1:1]}
  - arithmetic: {d[WIDTH-1], d[WIDTH-1:1]}, i.e. the sign bit is replicated from the register's current MSB.
- Mode 11 behaves exactly like 10.
- out is the data register itself. It changes only during SHIFT and on capture, and is stable in DONE and in IDLE afterwards.
- Overflow is not flagged. Bits shifted out are discarded, except in rotate mode.

## Timing
- Reset values: state=IDLE, out=0, busy=0, done=0, counter=0, mode/direction registers=0.
- Reset takes effect at the next edge from any state; reset mid-SHIFT abandons the operation with no done pulse.
- rst dominates start in the same cycle.
- Latency, with the start-accept cycle counted as cycle 0:
  - done=1 in cycle sl+1
  - busy=1 in cycles 1..sl+1
  - the earliest next accept is cycle sl+2
- sl=0: done in cycle 1, out=in.
- sl=WIDTH-1: WIDTH-1 SHIFT cycles, done in cycle WIDTH.
- start held high continuously: a new request is accepted on every IDLE cycle (back-to-back period sl+2).
- Intermediate out values are visible during SHIFT. Consumers must only sample out when done=1.

## Test plan
- Logic left: in=0xFFFF0000, sl=4, dir=0, mode=00 -> done in cycle 5, out=0xFFF00000; busy high in cycles 1-5 only.
- Logic right, then rotate right:
  - in=0xFFFF0000, sl=8, dir=1, mode=00 -> done in cycle 9, out=0x00FFFF00.
  - Then in=0x7FFF000A, sl=4, mode=01 -> out=0xA7FFF000.
- Arithmetic:
  - in=0xFFFF0000, sl=7, dir=1, mode=10 -> out=0xFFFFFE00.
  - in=0x7FFF0000, sl=3, dir=0, mode=11 -> out=0xFFF80000.
- Edges:
  - sl=0, in=0x12345678 -> done in cycle 1, out=0x12345678.
  - sl=31, rotate left, in=0x00000001 -> done in cycle 32, out=0x80000000.
- Busy-ignore: start pulsed with new operands in cycle 2 of an sl=6 request -> ignored; first result is unchanged and no extra done pulse appears.
- Reset mid-op: rst in cycle 3 of an sl=10 request -> next cycle busy=0, done=0, out=0, state IDLE; a start in the following cycle is accepted and completes normally.
